// File: rtl/interrupt_arbiter.sv
// -----------------------------------------------------------------------------
// interrupt_arbiter
//
// Decides when a pending, enabled machine-level interrupt is delivered to the
// pipeline. It picks one cause (external > software > timer), waits for the
// pipeline to reach an interruptible boundary and for no exception to be
// competing, and then raises a one-cycle trigger. It latches the mcause code,
// the return address and the external interrupt code. After it fires, it
// waits for the CSR unit to clear mstatus.MIE. If that does not happen within
// ACK_TIMEOUT cycles, it returns to idle anyway and raises a sticky error.
//
// Ports
//   clk                         in  1               clock
//   rst                         in  1               synchronous active-high reset
//   mstatusMIE                  in  1               global machine interrupt enable
//   mie                         in  3               {MEIE,MTIE,MSIE}
//   mip                         in  3               {MEIP,MTIP,MSIP}
//   externalInterruptCodeInCSR  in  EXT_CODE_WIDTH  external code latched by CSR unit
//   safePoint                   in  1               pipeline at an interruptible boundary
//   triggerExcpt                in  1               exception trap requested this cycle
//   headPC                      in  PC_WIDTH        PC of the oldest uncommitted instruction
//   triggerInterrupt            out 1               one-cycle interrupt request
//   interruptCode               out 4               mcause code (11 MEI, 3 MSI, 7 MTI)
//   interruptRetAddr            out PC_WIDTH        value for mepc
//   interruptExtCode            out EXT_CODE_WIDTH  external code captured with an MEI
//   ackTimeoutErr               out 1               sticky: MIE not cleared in time
// -----------------------------------------------------------------------------
module interrupt_arbiter #(
  parameter int PC_WIDTH       = 32,
  parameter int EXT_CODE_WIDTH = 5,
  parameter int ACK_TIMEOUT    = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mstatusMIE,
  input  logic [2:0]                mie,
  input  logic [2:0]                mip,
  input  logic [EXT_CODE_WIDTH-1:0] externalInterruptCodeInCSR,
  input  logic                      safePoint,
  input  logic                      triggerExcpt,
  input  logic [PC_WIDTH-1:0]       headPC,
  output logic                      triggerInterrupt,
  output logic [3:0]                interruptCode,
  output logic [PC_WIDTH-1:0]       interruptRetAddr,
  output logic [EXT_CODE_WIDTH-1:0] interruptExtCode,
  output logic                      ackTimeoutErr
);

  // mcause interrupt codes.
  localparam logic [3:0] CODE_MEI = 4'd11;
  localparam logic [3:0] CODE_MSI = 4'd3;
  localparam logic [3:0] CODE_MTI = 4'd7;

  // Bit positions inside mie/mip.
  localparam int BIT_MSI = 0;
  localparam int BIT_MTI = 1;
  localparam int BIT_MEI = 2;

  // The counter must hold ACK_TIMEOUT. It is kept at least one bit wide, so a
  // zero timeout still elaborates.
  localparam int CNT_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARM      = 2'd1,
    FIRE     = 2'd2,
    WAIT_CLR = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [3:0]                code_q;
  logic [PC_WIDTH-1:0]       ret_q;
  logic [EXT_CODE_WIDTH-1:0] ext_q;
  logic                      err_q;

  logic [2:0] pending_vec;
  logic       any_pending;
  logic [3:0] sel_code;
  logic       sel_is_mei;
  logic       latch_en;
  logic       set_err;

  // ---------------------------------------------------------------------------
  // Pending qualification and cause selection
  // ---------------------------------------------------------------------------
  assign pending_vec = mstatusMIE ? (mip & mie) : 3'b000;
  assign any_pending = |pending_vec;

  // Fixed priority: external > software > timer.
  always_comb begin
    // NOTE: every combinational output is given a default before any branch.
    // If a path left one unassigned, synthesis would infer a latch.
    sel_code   = 4'd0;
    sel_is_mei = 1'b0;
    if (pending_vec[BIT_MEI]) begin
      sel_code   = CODE_MEI;
      sel_is_mei = 1'b1;
    end else if (pending_vec[BIT_MSI]) begin
      sel_code = CODE_MSI;
    end else if (pending_vec[BIT_MTI]) begin
      sel_code = CODE_MTI;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    latch_en = 1'b0;
    set_err  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (any_pending) begin
          state_d = ARM;
        end
      end

      ARM: begin
        // A withdrawn request goes back to idle without firing. A competing
        // exception keeps us armed, so the trap is taken first.
        if (!any_pending) begin
          state_d = IDLE;
        end else if (safePoint && !triggerExcpt) begin
          state_d  = FIRE;
          latch_en = 1'b1;
        end
      end

      FIRE: begin
        state_d = WAIT_CLR;
        cnt_d   = CNT_LOAD;
      end

      WAIT_CLR: begin
        // The counter is loaded with ACK_TIMEOUT. The timeout fires on the
        // decrement that takes it to zero, so WAIT_CLR lasts ACK_TIMEOUT
        // cycles when MIE stays set.
        if (!mstatusMIE) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q <= CNT_ONE) begin
          state_d = IDLE;
          cnt_d   = '0;
          set_err = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and latched-output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments. All registers then
    // update together at the edge, whatever order the statements are in.
    if (rst) begin
      // NOTE: every register here is reset, including the datapath latches,
      // because software can read them right after reset.
      state_q <= IDLE;
      cnt_q   <= '0;
      code_q  <= '0;
      ret_q   <= '0;
      ext_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // The cause is captured only at the ARM->FIRE edge. Later changes on mip
      // leave the interrupt that was issued unchanged.
      if (latch_en) begin
        code_q <= sel_code;
        ret_q  <= headPC;
        ext_q  <= sel_is_mei ? externalInterruptCodeInCSR : '0;
      end
      if (set_err) begin
        err_q <= 1'b1;
      end
    end
  end

  assign triggerInterrupt = (state_q == FIRE);
  assign interruptCode    = code_q;
  assign interruptRetAddr = ret_q;
  assign interruptExtCode = ext_q;
  assign ackTimeoutErr    = err_q;

endmodule

// File: tb/tb_interrupt_arbiter.sv
// -----------------------------------------------------------------------------
// tb_interrupt_arbiter
//
// Directed scenarios first, then randomized traffic. Each cycle the outputs
// are compared with a cycle-level reference model. Some scenarios also check
// fixed expected values at key points.
// -----------------------------------------------------------------------------
module tb_interrupt_arbiter;

  localparam int PC_W  = 32;
  localparam int EXT_W = 5;
  localparam int ACK   = 15;

  logic             clk;
  logic             rst;
  logic             mstatus_mie;
  logic [2:0]       mie;
  logic [2:0]       mip;
  logic [EXT_W-1:0] ext_code;
  logic             safe_point;
  logic             trigger_excpt;
  logic [PC_W-1:0]  head_pc;
  logic             trig;
  logic [3:0]       code;
  logic [PC_W-1:0]  ret_addr;
  logic [EXT_W-1:0] ext_out;
  logic             timeout_err;

  int n_assert = 0;
  int n_fail   = 0;

  interrupt_arbiter #(
    .PC_WIDTH      (PC_W),
    .EXT_CODE_WIDTH(EXT_W),
    .ACK_TIMEOUT   (ACK)
  ) dut (
    .clk                       (clk),
    .rst                       (rst),
    .mstatusMIE                (mstatus_mie),
    .mie                       (mie),
    .mip                       (mip),
    .externalInterruptCodeInCSR(ext_code),
    .safePoint                 (safe_point),
    .triggerExcpt              (trigger_excpt),
    .headPC                    (head_pc),
    .triggerInterrupt          (trig),
    .interruptCode             (code),
    .interruptRetAddr          (ret_addr),
    .interruptExtCode          (ext_out),
    .ackTimeoutErr             (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model
  // The model is described in terms of behaviour, not encoding: it is either
  // armed, delivering, or waiting with a number of cycles still left.
  // ---------------------------------------------------------------------------
  bit              m_armed;
  bit              m_firing;
  int              m_wait_left;
  bit              m_err;
  logic [3:0]      m_code;
  logic [PC_W-1:0] m_ret;
  logic [EXT_W-1:0] m_ext;

  // Priority order as a table: {mip bit, mcause code}.
  int prio_bit  [3] = '{2, 0, 1};
  int prio_code [3] = '{11, 3, 7};

  task automatic model_step();
    logic [2:0] pend;
    pend = mstatus_mie ? (mip & mie) : 3'b000;
    if (rst) begin
      m_armed = 0; m_firing = 0; m_wait_left = 0; m_err = 0;
      m_code = '0; m_ret = '0; m_ext = '0;
    end else if (m_firing) begin
      m_firing    = 0;
      m_wait_left = ACK;
    end else if (m_wait_left > 0) begin
      if (!mstatus_mie) begin
        m_wait_left = 0;
      end else begin
        m_wait_left = m_wait_left - 1;
        if (m_wait_left == 0) m_err = 1;
      end
    end else if (m_armed) begin
      if (pend == 3'b000) begin
        m_armed = 0;
      end else if (safe_point && !trigger_excpt) begin
        m_armed  = 0;
        m_firing = 1;
        for (int i = 0; i < 3; i++) begin
          if (pend[prio_bit[i]]) begin
            m_code = 4'(prio_code[i]);
            m_ret  = head_pc;
            m_ext  = (prio_code[i] == 11) ? ext_code : '0;
            break;
          end
        end
      end
    end else if (pend != 3'b000) begin
      m_armed = 1;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".trig"}, 64'(trig),        64'(m_firing));
    check({tag, ".code"}, 64'(code),        64'(m_code));
    check({tag, ".ret"},  64'(ret_addr),    64'(m_ret));
    check({tag, ".ext"},  64'(ext_out),     64'(m_ext));
    check({tag, ".err"},  64'(timeout_err), 64'(m_err));
  endtask

  // Advance the model and the DUT by one clock edge, then compare the outputs
  // 1 time unit after the edge.
  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    rst = 1; mstatus_mie = 0; mie = 3'b000; mip = 3'b000; ext_code = '0;
    safe_point = 0; trigger_excpt = 0; head_pc = '0;

    // Reset state.
    tick("rst0");
    tick("rst1");
    check("rst_trig", 64'(trig), 64'd0);
    check("rst_code", 64'(code), 64'd0);

    // Basic MTI delivery with the two-cycle latency.
    rst = 0; mstatus_mie = 1; mie = 3'b111; safe_point = 1;
    head_pc = 32'h8000_0100; mip = 3'b010;
    tick("lat_c1");
    check("lat_c1_trig", 64'(trig), 64'd0);
    tick("lat_c2");
    check("lat_c2_trig", 64'(trig), 64'd1);
    check("lat_c2_code", 64'(code), 64'd7);
    check("lat_c2_ret",  64'(ret_addr), 64'h8000_0100);
    mstatus_mie = 0; mip = 3'b000;
    tick("lat_ack");
    check("single_pulse", 64'(trig), 64'd0);
    tick("lat_idle");

    // MEI wins over the others and carries the ext code. After that, MSI wins
    // over MTI.
    mip = 3'b111; ext_code = 5'd9; mstatus_mie = 1; head_pc = 32'h0000_2000;
    tick("mei_arm");
    tick("mei_fire");
    check("mei_code", 64'(code), 64'd11);
    check("mei_ext",  64'(ext_out), 64'd9);
    mstatus_mie = 0; mip = 3'b011;
    tick("mei_ack");
    mip = 3'b111;
    tick("mei_hold");
    check("latched_code_hold", 64'(code), 64'd11);
    mip = 3'b011;
    tick("mei_idle");
    mstatus_mie = 1;
    tick("msi_arm");
    tick("msi_fire");
    check("msi_code", 64'(code), 64'd3);
    check("msi_ext",  64'(ext_out), 64'd0);
    mstatus_mie = 0; mip = 3'b000;
    tick("msi_ack");
    tick("msi_idle");

    // Blocked by safePoint, then an exception arrives in the same cycle that
    // safePoint rises.
    mstatus_mie = 1; mip = 3'b001; safe_point = 0;
    tick("sp_arm");
    for (int i = 0; i < 5; i++) tick("sp_block");
    safe_point = 1; trigger_excpt = 1;
    tick("excpt");
    check("excpt_no_pulse", 64'(trig), 64'd0);
    trigger_excpt = 0;
    tick("excpt_drop");
    check("excpt_then_pulse", 64'(trig), 64'd1);
    mstatus_mie = 0; mip = 3'b000;
    tick("excpt_ack");
    tick("excpt_idle");

    // The request is withdrawn while armed.
    mstatus_mie = 1; mip = 3'b001; safe_point = 0;
    tick("wd_arm");
    mip = 3'b000;
    tick("wd_drop");
    safe_point = 1;
    tick("wd_quiet");
    check("wd_no_pulse", 64'(trig), 64'd0);
    mip = 3'b001;
    tick("wd_rearm");
    check("wd_back_in_idle", 64'(trig), 64'd0);
    tick("wd_fire");
    check("wd_fire_trig", 64'(trig), 64'd1);
    mstatus_mie = 0; mip = 3'b000;
    tick("wd_ack");
    tick("wd_idle");

    // Acknowledge timeout: MIE stays set after the fire.
    mstatus_mie = 1; mip = 3'b100; safe_point = 1;
    tick("to_arm");
    tick("to_fire");
    mip = 3'b000;
    for (int i = 0; i < ACK; i++) tick("to_wait");
    check("to_not_yet", 64'(timeout_err), 64'd0);
    tick("to_expire");
    check("to_err_set", 64'(timeout_err), 64'd1);
    for (int i = 0; i < 4; i++) tick("to_hold");
    mstatus_mie = 0;
    tick("to_sticky");
    check("to_err_sticky", 64'(timeout_err), 64'd1);

    // Reset during FIRE.
    mstatus_mie = 1; mip = 3'b001; head_pc = 32'h1234_5678;
    tick("rf_arm");
    tick("rf_fire");
    check("rf_fire_trig", 64'(trig), 64'd1);
    rst = 1;
    tick("rf_rst");
    check("rf_trig0", 64'(trig), 64'd0);
    check("rf_code0", 64'(code), 64'd0);
    check("rf_ret0",  64'(ret_addr), 64'd0);
    check("rf_err0",  64'(timeout_err), 64'd0);
    rst = 0;
    tick("rf_rearm");
    check("rf_no_second", 64'(trig), 64'd0);
    tick("rf_refire");
    mstatus_mie = 0; mip = 3'b000;
    tick("rf_ack");
    tick("rf_idle");

    // Randomized traffic, checked against the model every cycle.
    for (int i = 0; i < 600; i++) begin
      rst           = ($urandom_range(0, 99) == 0);
      mstatus_mie   = ($urandom_range(0, 3) != 0);
      mie           = 3'($urandom);
      mip           = 3'($urandom);
      ext_code      = 5'($urandom);
      safe_point    = ($urandom_range(0, 3) != 0);
      trigger_excpt = ($urandom_range(0, 7) == 0);
      head_pc       = $urandom;
      tick("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
